bch_encoder: RTL and testbench
==============================

# bch_encoder

Systematic BCH(15,5), t=3 encoder over GF(2^4), the transmit-side counterpart of the BCH syndrome/decoder chain. It accepts a 5-bit message through a valid/ready handshake and computes the 10 parity bits serially with a 10-stage LFSR. It then presents the 15-bit codeword through a second valid/ready handshake. Every codeword it emits yields S1 = S2 = S3 = 0 in `bch_syndrome_block`.

## Interface
- Parameters: none. `N=15`, `K=5` and `G=15'h0537` (g(x) = x^10+x^8+x^5+x^4+x^2+x+1) are fixed constants in `bch_pkg`.
- `clk` in 1: single clock, all logic rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `msg` in 5: message; `msg[4]` is the x^14 coefficient.
- `in_valid` in 1: `msg` is valid.
- `in_ready` out 1: encoder can accept a message.
- `codeword` out 15: `{msg[4:0], parity[9:0]}`; bit 14 = x^14, bit 0 = x^0.
- `out_valid` out 1: `codeword` is valid.
- `out_ready` in 1: downstream accepts `codeword`.

## Operation
- Codeword definition: c(x) = m(x)·x^10 + (m(x)·x^10 mod g(x)).
- The FSM has three states: IDLE, SHIFT, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid & in_ready`: latch `msg` into `msg_q`, clear LFSR `r[9:0]`, load `cnt`=4, go to SHIFT.
- SHIFT:
  - `in_ready`=0. Each cycle process bit b = `msg_q[cnt]`.
  - fb = b ^ r[9].
  - r <= {r[8:0],1'b0} ^ (fb ? G[9:0] : 10'h0).
  - When `cnt`=0, go to DONE; otherwise `cnt` decrements.
- DONE:
  - `out_valid`=1, `codeword`={`msg_q`, r}. Both stay stable until `out_ready`.
  - On `out_valid & out_ready`, go to IDLE.
- Back-pressure: `codeword` and `out_valid` hold indefinitely while `out_ready`=0. No new message is accepted until the handshake completes.
- `in_valid` while `in_ready`=0 is ignored; `msg` is not sampled.
- `out_ready` outside DONE has no effect.
- Reset, from any state including mid-SHIFT or DONE: the message is abandoned and the FSM returns to IDLE next edge.
  - Reset values: `in_ready`=0 during reset, `out_valid`=0, `codeword`=0, r=0, `cnt`=0, `msg_q`=0.
  - `in_ready`=1 in the first cycle after `rst` deasserts.
- All outputs are registered or decoded from state only. No combinational path from `in_valid`/`out_ready` to any output.

## Timing
- Accept edge T: state becomes SHIFT.
- Shift edges T+1..T+5: at T+5 the state becomes DONE.
- `out_valid` is high from after edge T+5 onward. Latency from the accept edge to `out_valid` is 5 cycles.
- If `out_ready`=1 on the first DONE cycle, the handshake completes at edge T+6.
- `in_ready` is high after T+6. The next accept is at T+7 at the earliest.
- Maximum throughput: one codeword per 7 cycles.
- `in_ready` and `out_valid` are never high in the same cycle.

## Structure
- `bch_pkg` holds:
  - `N`, `K`, `PARITY_W=10` and `G`.
  - The FSM state enum `bch_enc_state_t` (IDLE, SHIFT, DONE).
  - The `codeword_t` typedef (logic [14:0]).
- One natural sub-module: `bch_lfsr_div`, a 10-stage division LFSR. It has ports `clk`, `rst`, `clr`, `en`, `din`, `rem[9:0]`; the FSM sequences it.
- Everything else lives in `bch_encoder`.

## Test plan
- `msg`=5'b00000 → `codeword`=15'h0000, `out_valid` exactly 5 cycles after the accept edge.
- `msg`=5'b00001 → `codeword`=15'h0537, equal to g(x). `msg`=5'b00010 → 15'h0A6E.
- `msg`=5'b11111 → `codeword`=15'h7FFF (the all-ones codeword).
- Exhaustive, all 32 messages:
  - Each `codeword[14:10]` = `msg`.
  - Each codeword fed to `bch_syndrome_block` gives S1=S2=S3=4'b0000.
  - No duplicate codewords.
- Back-pressure:
  - Hold `out_ready`=0 for 10 cycles: `codeword` and `out_valid` are stable, `in_ready`=0.
  - A second `in_valid` pulse during this period is ignored.
  - Then raise `out_ready` → one transfer, `in_ready`=1 the next cycle.
- Reset mid-SHIFT (3rd shift cycle) → the next cycle `out_valid`=0, `codeword`=0 and `in_ready`=1 once `rst` drops.
  - A fresh `msg`=5'b00001 then encodes to 15'h0537.

Source files
------------

// File: rtl/bch_pkg.sv
// Shared constants and types for the BCH(15,5) t=3 encoder.
package bch_pkg;
    localparam int N        = 15;
    localparam int K        = 5;
    localparam int PARITY_W = 10;

    // g(x) = x^10 + x^8 + x^5 + x^4 + x^2 + x + 1
    localparam logic [14:0] G = 15'h0537;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bch_enc_state_t;

    typedef logic [N-1:0] codeword_t;
endpackage

// File: rtl/bch_lfsr_div.sv
// 10-stage division LFSR: after the message bits are fed MSB-first,
// rem holds m(x)*x^10 mod g(x).
module bch_lfsr_div
    import bch_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                en,
    input  logic                din,
    output logic [PARITY_W-1:0] rem
);

    logic [PARITY_W-1:0] r_rem;
    logic                w_fb;

    assign w_fb = din ^ r_rem[PARITY_W-1];

    // Remainder register: reset/clear to zero, otherwise one division step per enable
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem <= {PARITY_W{1'b0}};
        end else if (clr) begin
            r_rem <= {PARITY_W{1'b0}};
        end else if (en) begin
            r_rem <= {r_rem[PARITY_W-2:0], 1'b0} ^ (w_fb ? G[PARITY_W-1:0] : {PARITY_W{1'b0}});
        end else begin
            r_rem <= r_rem;
        end
    end

    assign rem = r_rem;

endmodule

// File: rtl/bch_encoder.sv
// Systematic BCH(15,5) encoder: accepts a message, shifts it through the
// division LFSR for five cycles and presents {msg, parity} until taken.
module bch_encoder
    import bch_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [K-1:0]     msg,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [N-1:0]     codeword,
    output logic             out_valid,
    input  logic             out_ready
);

    bch_enc_state_t      r_state;
    bch_enc_state_t      w_next_state;
    logic [2:0]          r_cnt;
    logic [K-1:0]        r_msg_q;
    logic                r_in_ready;
    logic                r_out_valid;
    logic                w_accept;
    logic                w_clr;
    logic                w_en;
    logic                w_din;
    logic                w_in_ready_nxt;
    logic                w_out_valid_nxt;
    logic [PARITY_W-1:0] w_rem;

    // r_in_ready is only ever set while the FSM sits in IDLE
    assign w_accept = in_valid & r_in_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = SHIFT;
                end else begin
                    w_next_state = IDLE;
                end
            end
            SHIFT: begin
                if (r_cnt == 3'd0) begin
                    w_next_state = DONE;
                end else begin
                    w_next_state = SHIFT;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = DONE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Output/control decode; handshake flags are computed one cycle ahead and registered
    always_comb begin
        w_clr           = w_accept;
        w_en            = (r_state == SHIFT);
        w_din           = r_msg_q[r_cnt];
        w_in_ready_nxt  = (w_next_state == IDLE);
        w_out_valid_nxt = (w_next_state == DONE);
    end

    // Message latch, bit counter and registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_msg_q     <= {K{1'b0}};
            r_cnt       <= 3'd0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
            if (w_accept) begin
                r_msg_q <= msg;
                r_cnt   <= 3'd4;
            end else if ((r_state == SHIFT) && (r_cnt != 3'd0)) begin
                r_msg_q <= r_msg_q;
                r_cnt   <= r_cnt - 3'd1;
            end else begin
                r_msg_q <= r_msg_q;
                r_cnt   <= r_cnt;
            end
        end
    end

    bch_lfsr_div u_lfsr (
        .clk (clk),
        .rst (rst),
        .clr (w_clr),
        .en  (w_en),
        .din (w_din),
        .rem (w_rem)
    );

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign codeword  = {r_msg_q, w_rem};

endmodule

// File: tb/tb_bch_encoder.sv
// Directed self-checking bench for bch_encoder: known vectors, all 32
// messages against a polynomial-division model and GF(16) syndromes,
// back-pressure and mid-shift reset.
module tb_bch_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  msg;
    logic        in_valid;
    logic        in_ready;
    logic [14:0] codeword;
    logic        out_valid;
    logic        out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    logic [14:0] cw_tab [32];

    always #5 clk = ~clk;

    bch_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .msg       (msg),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .codeword  (codeword),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: long division of m(x)*x^10 by g(x)
    function automatic logic [14:0] model_cw(input logic [4:0] m);
        logic [14:0] d;
        logic [14:0] g;
        g = 15'h0537;
        d = {m, 10'b0};
        for (int i = 14; i >= 10; i--) begin
            if (d[i]) d = d ^ (g << (i - 10));
        end
        return {m, d[9:0]};
    endfunction

    // {S1,S2,S3} = c(alpha), c(alpha^2), c(alpha^3) over GF(16), x^4+x+1
    function automatic logic [11:0] syndromes(input logic [14:0] c);
        logic [3:0] pw [15];
        logic [3:0] a;
        logic [3:0] s [3];
        a = 4'h1;
        for (int j = 0; j < 15; j++) begin
            pw[j] = a;
            a = {a[2:0], 1'b0} ^ (a[3] ? 4'h3 : 4'h0);
        end
        for (int i = 0; i < 3; i++) begin
            s[i] = 4'h0;
            for (int j = 0; j < 15; j++) begin
                if (c[j]) s[i] = s[i] ^ pw[((i + 1) * j) % 15];
            end
        end
        return {s[0], s[1], s[2]};
    endfunction

    task automatic encode(input logic [4:0] m, output logic [14:0] cw, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 20) begin
            tick();
            guard++;
        end
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        msg      = m;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        cw = codeword;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("out_valid_after_xfer", 32'(out_valid), 32'd0);
        check("in_ready_after_xfer", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [14:0] cw;
        logic [14:0] exp_cw;
        logic [4:0]  dir_msg [4];
        logic [14:0] dir_exp [4];
        int          lat;
        int          dups;

        dir_msg[0] = 5'b00000; dir_exp[0] = 15'h0000;
        dir_msg[1] = 5'b00001; dir_exp[1] = 15'h0537;
        dir_msg[2] = 5'b00010; dir_exp[2] = 15'h0A6E;
        dir_msg[3] = 5'b11111; dir_exp[3] = 15'h7FFF;

        rst       = 1'b1;
        msg       = 5'b00000;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        check("reset_in_ready", 32'(in_ready), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_codeword", 32'(codeword), 32'd0);
        rst = 1'b0;
        tick();
        check("post_reset_in_ready", 32'(in_ready), 32'd1);
        check("post_reset_out_valid", 32'(out_valid), 32'd0);

        // Directed vectors with hand-computed codewords
        for (int i = 0; i < 4; i++) begin
            encode(dir_msg[i], cw, lat);
            check("dir_latency", 32'(lat), 32'd5);
            check("dir_codeword", 32'(cw), 32'(dir_exp[i]));
            check("dir_in_ready_in_done", 32'(in_ready), 32'd0);
            handshake();
        end

        // All 32 messages
        for (int m = 0; m < 32; m++) begin
            encode(5'(m), cw, lat);
            cw_tab[m] = cw;
            check("exh_latency", 32'(lat), 32'd5);
            check("exh_codeword", 32'(cw), 32'(model_cw(5'(m))));
            check("exh_systematic", 32'(cw[14:10]), 32'(m));
            check("exh_syndromes", 32'(syndromes(cw)), 32'd0);
            handshake();
        end
        dups = 0;
        for (int a = 0; a < 32; a++) begin
            for (int b = a + 1; b < 32; b++) begin
                if (cw_tab[a] == cw_tab[b]) dups++;
            end
        end
        check("exh_no_duplicates", 32'(dups), 32'd0);

        // Back-pressure with an ignored in_valid pulse
        exp_cw = model_cw(5'b10110);
        encode(5'b10110, cw, lat);
        check("bp_latency", 32'(lat), 32'd5);
        check("bp_codeword", 32'(cw), 32'(exp_cw));
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                msg      = 5'b01001;
                in_valid = 1'b1;
            end
            tick();
            in_valid = 1'b0;
            check("bp_hold_codeword", 32'(codeword), 32'(exp_cw));
            check("bp_hold_out_valid", 32'(out_valid), 32'd1);
            check("bp_hold_in_ready", 32'(in_ready), 32'd0);
        end
        handshake();

        // Reset during the third shift cycle
        msg      = 5'b11010;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_codeword", 32'(codeword), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        tick();
        check("midrst_in_ready_after", 32'(in_ready), 32'd1);
        encode(5'b00001, cw, lat);
        check("midrst_latency", 32'(lat), 32'd5);
        check("midrst_codeword_fresh", 32'(cw), 32'h0537);
        handshake();

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
